// File: rtl/multi_cycle_control_unit.sv
// -----------------------------------------------------------------------------
// multi_cycle_control_unit
//
// Sequencing FSM for the multi-cycle RV32I core. Each instruction is stepped
// through fetch, decode, execute, memory and write-back states. The unit drives
// the datapath mux selects, the register/memory enables and the ALU mode. It
// waits on the shared instruction/data memory through the mem_ready handshake.
//
// Ports
//   clk        in   clock, all state changes on posedge
//   reset      in   synchronous, active-high
//   opcode     in   IR[6:0], valid from ID onward
//   alu_bcond  in   ALU branch condition (used in EX_BR only)
//   mem_ready  in   memory completes the current read/write this cycle
//   halt_req   in   ECALL with x17 == 10
//   pc_write   out  load PC at next edge
//   pc_source  out  0 = ALU result, 1 = ALUOut register
//   i_or_d     out  memory address: 0 = PC, 1 = ALUOut
//   mem_read   out  memory read strobe
//   mem_write  out  memory write strobe
//   ir_write   out  latch IR and old_pc
//   reg_write  out  register-file write enable
//   mem_to_reg out  write data from memory
//   pc_to_reg  out  write data from PC (link address)
//   alu_src_a  out  0 = PC, 1 = A, 2 = old_pc
//   alu_src_b  out  0 = B, 1 = constant 4, 2 = immediate
//   alu_mode   out  0 = ADD, 1 = SUB, 2 = decode funct3/funct7
//   halted     out  core stopped
//   state      out  current state code, for debug
// -----------------------------------------------------------------------------
module multi_cycle_control_unit (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       alu_bcond,
   input  logic       mem_ready,
   input  logic       halt_req,
   output logic       pc_write,
   output logic       pc_source,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic       mem_to_reg,
   output logic       pc_to_reg,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_mode,
   output logic       halted,
   output logic [3:0] state
);

   localparam logic [6:0] OP_ARITH     = 7'b0110011;
   localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
   localparam logic [6:0] OP_LOAD      = 7'b0000011;
   localparam logic [6:0] OP_STORE     = 7'b0100011;
   localparam logic [6:0] OP_BRANCH    = 7'b1100011;
   localparam logic [6:0] OP_JAL       = 7'b1101111;
   localparam logic [6:0] OP_JALR      = 7'b1100111;
   localparam logic [6:0] OP_ECALL     = 7'b1110011;

   typedef enum logic [3:0] {
      S_IF      = 4'd0,
      S_ID      = 4'd1,
      S_EX_R    = 4'd2,
      S_EX_I    = 4'd3,
      S_EX_ADDR = 4'd4,
      S_MEM_LD  = 4'd5,
      S_MEM_ST  = 4'd6,
      S_WB_ALU  = 4'd7,
      S_WB_LD   = 4'd8,
      S_EX_BR   = 4'd9,
      S_EX_JAL  = 4'd10,
      S_EX_JALR = 4'd11,
      S_HALT    = 4'd12
   } state_t;

   state_t state_q;
   state_t state_d;
   logic   halted_q;

   // Raw enables before the reset gate.
   logic pc_write_s;
   logic ir_write_s;
   logic reg_write_s;
   logic mem_read_s;
   logic mem_write_s;

   // Next-state decode.
   always_comb begin
      state_d = S_IF;
      case (state_q)
         S_IF:      state_d = mem_ready ? S_ID : S_IF;
         S_ID: begin
            case (opcode)
               OP_ARITH:     state_d = S_EX_R;
               OP_ARITH_IMM: state_d = S_EX_I;
               OP_LOAD:      state_d = S_EX_ADDR;
               OP_STORE:     state_d = S_EX_ADDR;
               OP_BRANCH:    state_d = S_EX_BR;
               OP_JAL:       state_d = S_EX_JAL;
               OP_JALR:      state_d = S_EX_JALR;
               OP_ECALL:     state_d = halt_req ? S_HALT : S_IF;
               default:      state_d = S_IF;   // unsupported opcode retires as a no-op
            endcase
         end
         S_EX_R:    state_d = S_WB_ALU;
         S_EX_I:    state_d = S_WB_ALU;
         S_EX_ADDR: begin
            if (opcode == OP_LOAD) begin
               state_d = S_MEM_LD;
            end else if (opcode == OP_STORE) begin
               state_d = S_MEM_ST;
            end else begin
               state_d = S_IF;
            end
         end
         S_MEM_LD:  state_d = mem_ready ? S_WB_LD : S_MEM_LD;
         S_MEM_ST:  state_d = mem_ready ? S_IF : S_MEM_ST;
         S_WB_ALU:  state_d = S_IF;
         S_WB_LD:   state_d = S_IF;
         S_EX_BR:   state_d = S_IF;
         S_EX_JAL:  state_d = S_IF;
         S_EX_JALR: state_d = S_IF;
         S_HALT:    state_d = S_HALT;
         default:   state_d = S_IF;
      endcase
   end

   // State and halted flag; reset abandons any instruction in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IF;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         halted_q <= (state_d == S_HALT);
      end
   end

   // Moore output decode; only IF enables depend on mem_ready and only the
   // EX_BR pc_write depends on alu_bcond.
   always_comb begin
      pc_write_s  = 1'b0;
      ir_write_s  = 1'b0;
      reg_write_s = 1'b0;
      mem_read_s  = 1'b0;
      mem_write_s = 1'b0;
      pc_source   = 1'b0;
      i_or_d      = 1'b0;
      mem_to_reg  = 1'b0;
      pc_to_reg   = 1'b0;
      alu_src_a   = 2'd0;
      alu_src_b   = 2'd0;
      alu_mode    = 2'd0;
      case (state_q)
         S_IF: begin
            mem_read_s = 1'b1;
            alu_src_b  = 2'd1;
            pc_write_s = mem_ready;
            ir_write_s = mem_ready;
         end
         S_ID: begin
            alu_src_a = 2'd2;
            alu_src_b = 2'd2;
         end
         S_EX_R: begin
            alu_src_a = 2'd1;
            alu_mode  = 2'd2;
         end
         S_EX_I: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd2;
            alu_mode  = 2'd2;
         end
         S_WB_ALU: begin
            // Keep the ALU inputs of the preceding EX state so ALU result is stable.
            alu_src_a   = 2'd1;
            alu_src_b   = (opcode == OP_ARITH_IMM) ? 2'd2 : 2'd0;
            alu_mode    = 2'd2;
            reg_write_s = 1'b1;
         end
         S_EX_ADDR: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd2;
         end
         S_MEM_LD: begin
            mem_read_s = 1'b1;
            i_or_d     = 1'b1;
         end
         S_WB_LD: begin
            reg_write_s = 1'b1;
            mem_to_reg  = 1'b1;
         end
         S_MEM_ST: begin
            mem_write_s = 1'b1;
            i_or_d      = 1'b1;
         end
         S_EX_BR: begin
            alu_src_a  = 2'd1;
            alu_mode   = 2'd1;
            pc_write_s = alu_bcond;
            pc_source  = 1'b1;
         end
         S_EX_JAL: begin
            reg_write_s = 1'b1;
            pc_to_reg   = 1'b1;
            pc_write_s  = 1'b1;
            pc_source   = 1'b1;
         end
         S_EX_JALR: begin
            alu_src_a   = 2'd1;
            alu_src_b   = 2'd2;
            reg_write_s = 1'b1;
            pc_to_reg   = 1'b1;
            pc_write_s  = 1'b1;
         end
         S_HALT: begin
            pc_write_s = 1'b0;
         end
         default: begin
            pc_write_s = 1'b0;
         end
      endcase
   end

   // No architectural write may fire while reset is held.
   assign pc_write  = pc_write_s  & ~reset;
   assign ir_write  = ir_write_s  & ~reset;
   assign reg_write = reg_write_s & ~reset;
   assign mem_read  = mem_read_s  & ~reset;
   assign mem_write = mem_write_s & ~reset;

   assign halted = halted_q;
   assign state  = state_q;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Directed bench for multi_cycle_control_unit. Each instruction class is
// expanded into its expected per-cycle output records; a compare process
// checks the DUT against the current record every cycle.
module tb_multi_cycle_control_unit;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_ECALL = 7'b1110011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, pcs, iod, mrd, mwr, irw, rw, m2r, p2r;
      logic [1:0] a, b, m;
      logic       hlt;
   } rec_t;

   logic clk = 1'b0;
   logic reset, alu_bcond, mem_ready, halt_req;
   logic [6:0] opcode;
   logic pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write;
   logic reg_write, mem_to_reg, pc_to_reg, halted;
   logic [1:0] alu_src_a, alu_src_b, alu_mode;
   logic [3:0] state;

   rec_t act;
   rec_t exp_r;
   logic exp_v = 1'b0;

   int total = 0;
   int bad = 0;
   int commits = 0;
   int cnt = 0;
   logic [3:0] prev_st = 4'hF;
   int want_len = 0;
   int want_seq = 0;
   int seen_seq = 0;
   string want_tag = "";
   string cur_tag = "reset";
   logic [6:0] cur_op = 7'd0;
   logic cur_halt = 1'b0;
   logic cur_bc = 1'b0;
   logic final_chk = 1'b0;
   logic final_done = 1'b0;

   multi_cycle_control_unit dut (
      .clk(clk), .reset(reset), .opcode(opcode), .alu_bcond(alu_bcond),
      .mem_ready(mem_ready), .halt_req(halt_req),
      .pc_write(pc_write), .pc_source(pc_source), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_write(reg_write), .mem_to_reg(mem_to_reg), .pc_to_reg(pc_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_mode(alu_mode),
      .halted(halted), .state(state)
   );

   always #5 clk = ~clk;

   assign act = {state, pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
                 reg_write, mem_to_reg, pc_to_reg, alu_src_a, alu_src_b, alu_mode, halted};

   // Per-cycle compare, instruction-length pins and store-commit count.
   always @(negedge clk) begin
      #2;
      if (exp_v) begin
         total++;
         if (act !== exp_r) begin
            bad++;
            $display("FAIL %s: actual st=%0d outs=%b required st=%0d outs=%b",
                     cur_tag, act.st, act, exp_r.st, exp_r);
         end
         if (mem_write === 1'b1 && mem_ready === 1'b1) commits++;
         if (reset) begin
            cnt = 0;
            prev_st = 4'hF;
         end else begin
            if (act.st == 4'd0 && prev_st != 4'd0) begin
               if (want_seq != seen_seq) begin
                  total++;
                  if (cnt != want_len) begin
                     bad++;
                     $display("FAIL len %s: cycles=%0d required=%0d", want_tag, cnt, want_len);
                  end
                  seen_seq = want_seq;
               end
               cnt = 1;
            end else begin
               cnt++;
            end
            prev_st = act.st;
         end
      end
      if (final_chk && !final_done) begin
         total++;
         if (commits != 2) begin
            bad++;
            $display("FAIL store_commits: count=%0d required=%0d", commits, 2);
         end
         final_done = 1'b1;
      end
   end

   function automatic rec_t z(input logic [3:0] st);
      rec_t r;
      r = '0;
      r.st = st;
      return r;
   endfunction

   task automatic step(input rec_t e, input logic rdy, input logic bc, input logic rst);
      @(negedge clk);
      opcode = cur_op; halt_req = cur_halt; mem_ready = rdy; alu_bcond = bc; reset = rst;
      exp_r = e; exp_v = 1'b1;
   endtask

   task automatic pin(input int n);
      want_len = n; want_tag = cur_tag; want_seq++;
   endtask

   task automatic fetch(input int waits);
      rec_t e;
      for (int i = 0; i < waits; i++) begin
         e = z(4'd0); e.mrd = 1'b1; e.b = 2'd1;
         step(e, 1'b0, cur_bc, 1'b0);
      end
      e = z(4'd0); e.mrd = 1'b1; e.b = 2'd1; e.pcw = 1'b1; e.irw = 1'b1;
      step(e, 1'b1, cur_bc, 1'b0);
   endtask

   task automatic decode();
      rec_t e;
      e = z(4'd1); e.a = 2'd2; e.b = 2'd2;
      step(e, 1'b0, cur_bc, 1'b0);   // mem_ready ignored here
   endtask

   task automatic addr_step();
      rec_t e;
      e = z(4'd4); e.a = 2'd1; e.b = 2'd2;
      step(e, 1'b1, cur_bc, 1'b0);
   endtask

   task automatic instr(input string tag, input logic [6:0] op, input int if_w,
                        input int mem_w, input logic bc, input logic hr);
      rec_t e;
      cur_tag = tag; cur_op = op; cur_halt = hr; cur_bc = bc;
      fetch(if_w);
      decode();
      case (op)
         OP_R: begin
            e = z(4'd2); e.a = 2'd1; e.m = 2'd2; step(e, 1'b1, bc, 1'b0);
            e = z(4'd7); e.a = 2'd1; e.m = 2'd2; e.rw = 1'b1; step(e, 1'b0, bc, 1'b0);
         end
         OP_I: begin
            e = z(4'd3); e.a = 2'd1; e.b = 2'd2; e.m = 2'd2; step(e, 1'b1, bc, 1'b0);
            e = z(4'd7); e.a = 2'd1; e.b = 2'd2; e.m = 2'd2; e.rw = 1'b1; step(e, 1'b0, bc, 1'b0);
         end
         OP_LOAD: begin
            addr_step();
            e = z(4'd5); e.mrd = 1'b1; e.iod = 1'b1;
            for (int i = 0; i < mem_w; i++) step(e, 1'b0, bc, 1'b0);
            step(e, 1'b1, bc, 1'b0);
            e = z(4'd8); e.rw = 1'b1; e.m2r = 1'b1; step(e, 1'b1, bc, 1'b0);
         end
         OP_STORE: begin
            addr_step();
            e = z(4'd6); e.mwr = 1'b1; e.iod = 1'b1;
            for (int i = 0; i < mem_w; i++) step(e, 1'b0, bc, 1'b0);
            step(e, 1'b1, bc, 1'b0);
         end
         OP_BR: begin
            e = z(4'd9); e.a = 2'd1; e.m = 2'd1; e.pcs = 1'b1; e.pcw = bc;
            step(e, 1'b0, bc, 1'b0);
         end
         OP_JAL: begin
            e = z(4'd10); e.rw = 1'b1; e.p2r = 1'b1; e.pcw = 1'b1; e.pcs = 1'b1;
            step(e, 1'b1, bc, 1'b0);
         end
         OP_JALR: begin
            e = z(4'd11); e.a = 2'd1; e.b = 2'd2; e.rw = 1'b1; e.p2r = 1'b1; e.pcw = 1'b1;
            step(e, 1'b1, bc, 1'b0);
         end
         OP_ECALL: begin
            if (hr) begin
               e = z(4'd12); e.hlt = 1'b1;
               for (int i = 0; i < 10; i++) step(e, i[0], ~i[0], 1'b0);
            end
         end
         default: begin
         end
      endcase
   endtask

   initial begin
      rec_t e;
      reset = 1'b1; opcode = 7'd0; alu_bcond = 1'b0; mem_ready = 1'b0; halt_req = 1'b0;
      // Second reset cycle: state IF, enables forced low, halted low.
      e = z(4'd0); e.b = 2'd1;
      step(e, 1'b0, 1'b0, 1'b1);

      instr("addi", OP_I, 0, 0, 1'b0, 1'b0);      pin(4);
      instr("add", OP_R, 2, 0, 1'b0, 1'b0);       pin(6);
      instr("lw", OP_LOAD, 0, 3, 1'b0, 1'b0);     pin(8);
      instr("sw", OP_STORE, 0, 0, 1'b0, 1'b0);    pin(4);
      instr("sw_wait", OP_STORE, 1, 2, 1'b0, 1'b0); pin(7);
      instr("beq_t", OP_BR, 0, 0, 1'b1, 1'b0);    pin(3);
      instr("beq_nt", OP_BR, 0, 0, 1'b0, 1'b0);   pin(3);
      instr("jal", OP_JAL, 0, 0, 1'b0, 1'b0);     pin(3);
      instr("jalr", OP_JALR, 0, 0, 1'b1, 1'b0);   pin(3);
      instr("lui_nop", OP_LUI, 0, 0, 1'b0, 1'b0); pin(2);
      instr("ecall_nop", OP_ECALL, 0, 0, 1'b0, 1'b0); pin(2);

      // Store abandoned by reset while waiting on memory.
      cur_tag = "sw_abort"; cur_op = OP_STORE; cur_halt = 1'b0; cur_bc = 1'b0;
      fetch(0);
      decode();
      addr_step();
      e = z(4'd6); e.mwr = 1'b1; e.iod = 1'b1;
      step(e, 1'b0, 1'b0, 1'b0);
      e.mwr = 1'b0;                      // forced off during reset even with mem_ready high
      step(e, 1'b1, 1'b0, 1'b1);

      instr("addi2", OP_I, 0, 0, 1'b0, 1'b0);     pin(4);
      instr("ecall_halt", OP_ECALL, 0, 0, 1'b0, 1'b1);

      // Leave HALT through reset.
      cur_tag = "halt_reset";
      e = z(4'd12); e.hlt = 1'b1;
      step(e, 1'b1, 1'b0, 1'b1);

      instr("addi3", OP_I, 0, 0, 1'b0, 1'b0);     pin(4);
      cur_tag = "tail"; cur_op = OP_I;
      fetch(0);

      @(negedge clk);
      exp_v = 1'b0;
      final_chk = 1'b1;
      @(negedge clk);
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
